// File: rtl/dma_mem_responder.sv
// dma_mem_responder
//
// Responder end of the dma_if peripheral protocol: a cycle-accurate,
// memory-backed DMA model. An initiator (cache-test AFU, cache hierarchy)
// reads cache lines through a first-word-fall-through read FIFO and writes
// cache lines through a write FIFO that drains into a line-addressed memory.
// A backdoor port preloads and inspects the memory.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   rd_go, rd_addr, rd_size       start a read of rd_size lines at rd_addr
//   rd_en, rd_data, empty         FWFT read FIFO: pop / head / empty flag
//   rd_done                       every requested line has been popped
//   wr_go, wr_addr, wr_size       start a write of wr_size lines at wr_addr
//   wr_en, wr_data, full          write FIFO: push / data / full flag
//   wr_done                       every requested line is in memory
//   bd_we, bd_addr, bd_wdata      backdoor line write
//   bd_rdata                      combinational mem[bd_addr]
module dma_mem_responder #(
    parameter int DATA_WIDTH        = 512,
    parameter int ADDR_WIDTH        = 64,
    parameter int SIZE_WIDTH        = 17,
    parameter int MEM_LINES         = 1024,
    parameter int FIFO_DEPTH        = 4,
    parameter int WR_DRAIN_INTERVAL = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rd_go,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    input  logic [SIZE_WIDTH-1:0]        rd_size,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         empty,
    output logic                         rd_done,
    input  logic                         wr_go,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [SIZE_WIDTH-1:0]        wr_size,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         full,
    output logic                         wr_done,
    input  logic                         bd_we,
    input  logic [$clog2(MEM_LINES)-1:0] bd_addr,
    input  logic [DATA_WIDTH-1:0]        bd_wdata,
    output logic [DATA_WIDTH-1:0]        bd_rdata
);

    localparam int LINE_W = $clog2(MEM_LINES);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IVL_W  = (WR_DRAIN_INTERVAL > 1) ? $clog2(WR_DRAIN_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [IVL_W-1:0] IVL_LAST = IVL_W'(WR_DRAIN_INTERVAL - 1);

    typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_DRAIN, RD_DONE} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_ACCEPT, WR_DONE} wr_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_LINES];

    // Read channel
    rd_state_t             rd_state_q, rd_state_d;
    logic [LINE_W-1:0]     rd_base_q, rd_base_d;
    logic [SIZE_WIDTH-1:0] rd_size_q, rd_size_d;
    logic [SIZE_WIDTH-1:0] rd_issued_q, rd_issued_d;
    logic [SIZE_WIDTH-1:0] rd_popped_q, rd_popped_d;
    logic [CNT_W-1:0]      rd_count_q, rd_count_d;
    logic [PTR_W-1:0]      rd_wptr_q, rd_wptr_d, rd_rptr_q, rd_rptr_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic                  rd_empty_q, rd_empty_d;
    logic [DATA_WIDTH-1:0] rd_mem_q;
    logic [DATA_WIDTH-1:0] rd_fifo [FIFO_DEPTH];
    logic                  rd_issue, rd_push, rd_pop;
    logic [LINE_W-1:0]     rd_line;

    // Write channel
    wr_state_t             wr_state_q, wr_state_d;
    logic [LINE_W-1:0]     wr_base_q, wr_base_d;
    logic [SIZE_WIDTH-1:0] wr_size_q, wr_size_d;
    logic [SIZE_WIDTH-1:0] wr_accepted_q, wr_accepted_d;
    logic [SIZE_WIDTH-1:0] wr_drained_q, wr_drained_d;
    logic [CNT_W-1:0]      wr_count_q, wr_count_d;
    logic [PTR_W-1:0]      wr_wptr_q, wr_wptr_d, wr_rptr_q, wr_rptr_d;
    logic [IVL_W-1:0]      wr_wait_q, wr_wait_d;
    logic                  wr_full_q, wr_full_d;
    logic [DATA_WIDTH-1:0] wr_fifo [FIFO_DEPTH];
    logic                  wr_push, wr_drain;
    logic [LINE_W-1:0]     wr_line;

    // Only the line-index bits of the byte addresses are meaningful.
    logic unused_ok;
    assign unused_ok = ^{rd_addr, wr_addr};

    // ------------------------------------------------------------------
    // Read FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        rd_state_d    = rd_state_q;
        rd_base_d     = rd_base_q;
        rd_size_d     = rd_size_q;
        rd_issued_d   = rd_issued_q;
        rd_popped_d   = rd_popped_q;
        rd_count_d    = rd_count_q;
        rd_wptr_d     = rd_wptr_q;
        rd_rptr_d     = rd_rptr_q;
        rd_inflight_d = rd_inflight_q;
        rd_issue      = 1'b0;
        rd_push       = 1'b0;
        rd_pop        = 1'b0;
        rd_line       = rd_base_q + rd_issued_q[LINE_W-1:0];

        if (rd_go) begin
            // A new request discards everything buffered or in flight.
            rd_base_d     = rd_addr[6 +: LINE_W];
            rd_size_d     = rd_size;
            rd_issued_d   = '0;
            rd_popped_d   = '0;
            rd_count_d    = '0;
            rd_wptr_d     = '0;
            rd_rptr_d     = '0;
            rd_inflight_d = 1'b0;
            rd_state_d    = (rd_size == '0) ? RD_DONE : RD_FETCH;
        end else begin
            rd_push  = rd_inflight_q;
            rd_pop   = rd_en && !rd_empty_q;
            // Reserve a slot for the read already in flight so the FIFO
            // can never overflow.
            rd_issue = (rd_state_q == RD_FETCH) && (rd_issued_q != rd_size_q) &&
                       ((rd_count_q + CNT_W'(rd_inflight_q)) < DEPTH_C);
            rd_inflight_d = rd_issue;
            if (rd_issue) rd_issued_d = rd_issued_q + SIZE_WIDTH'(1);
            if (rd_push)  rd_wptr_d   = rd_wptr_q + PTR_W'(1);
            if (rd_pop) begin
                rd_rptr_d   = rd_rptr_q + PTR_W'(1);
                rd_popped_d = rd_popped_q + SIZE_WIDTH'(1);
            end
            rd_count_d = rd_count_q + CNT_W'(rd_push) - CNT_W'(rd_pop);

            case (rd_state_q)
                RD_FETCH: begin
                    if (rd_popped_d == rd_size_q)      rd_state_d = RD_DONE;
                    else if (rd_issued_d == rd_size_q) rd_state_d = RD_DRAIN;
                end
                RD_DRAIN: begin
                    if (rd_popped_d == rd_size_q) rd_state_d = RD_DONE;
                end
                default: ;
            endcase
        end
        rd_empty_d = (rd_count_d == '0);
    end

    // ------------------------------------------------------------------
    // Read FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q    <= RD_IDLE;
            rd_base_q     <= '0;
            rd_size_q     <= '0;
            rd_issued_q   <= '0;
            rd_popped_q   <= '0;
            rd_count_q    <= '0;
            rd_wptr_q     <= '0;
            rd_rptr_q     <= '0;
            rd_inflight_q <= 1'b0;
            rd_empty_q    <= 1'b1;
        end else begin
            rd_state_q    <= rd_state_d;
            rd_base_q     <= rd_base_d;
            rd_size_q     <= rd_size_d;
            rd_issued_q   <= rd_issued_d;
            rd_popped_q   <= rd_popped_d;
            rd_count_q    <= rd_count_d;
            rd_wptr_q     <= rd_wptr_d;
            rd_rptr_q     <= rd_rptr_d;
            rd_inflight_q <= rd_inflight_d;
            rd_empty_q    <= rd_empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_push) rd_fifo[rd_wptr_q] <= rd_mem_q;
    end

    // Head is forced to zero while empty so rd_data is 0 out of reset.
    assign rd_data = rd_empty_q ? '0 : rd_fifo[rd_rptr_q];
    assign empty   = rd_empty_q;
    assign rd_done = (rd_state_q == RD_DONE);

    // ------------------------------------------------------------------
    // Write FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_state_d    = wr_state_q;
        wr_base_d     = wr_base_q;
        wr_size_d     = wr_size_q;
        wr_accepted_d = wr_accepted_q;
        wr_drained_d  = wr_drained_q;
        wr_count_d    = wr_count_q;
        wr_wptr_d     = wr_wptr_q;
        wr_rptr_d     = wr_rptr_q;
        wr_wait_d     = wr_wait_q;
        wr_push       = 1'b0;
        wr_drain      = 1'b0;
        wr_line       = wr_base_q + wr_drained_q[LINE_W-1:0];

        if (wr_go) begin
            wr_base_d     = wr_addr[6 +: LINE_W];
            wr_size_d     = wr_size;
            wr_accepted_d = '0;
            wr_drained_d  = '0;
            wr_count_d    = '0;
            wr_wptr_d     = '0;
            wr_rptr_d     = '0;
            wr_wait_d     = '0;
            wr_state_d    = (wr_size == '0) ? WR_DONE : WR_ACCEPT;
        end else if (wr_state_q == WR_ACCEPT) begin
            wr_push  = wr_en && !wr_full_q && (wr_accepted_q != wr_size_q);
            // The head must sit in the FIFO for WR_DRAIN_INTERVAL cycles
            // before it drains; rst blocks the memory write outright.
            wr_drain = !rst && (wr_count_q != '0) && (wr_wait_q == IVL_LAST);
            if (wr_drain)                wr_wait_d = '0;
            else if (wr_count_q != '0)   wr_wait_d = wr_wait_q + IVL_W'(1);
            if (wr_push) begin
                wr_wptr_d     = wr_wptr_q + PTR_W'(1);
                wr_accepted_d = wr_accepted_q + SIZE_WIDTH'(1);
            end
            if (wr_drain) begin
                wr_rptr_d    = wr_rptr_q + PTR_W'(1);
                wr_drained_d = wr_drained_q + SIZE_WIDTH'(1);
            end
            wr_count_d = wr_count_q + CNT_W'(wr_push) - CNT_W'(wr_drain);
            if (wr_drained_d == wr_size_q) wr_state_d = WR_DONE;
        end
        wr_full_d = (wr_count_d == DEPTH_C);
    end

    // ------------------------------------------------------------------
    // Write FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q    <= WR_IDLE;
            wr_base_q     <= '0;
            wr_size_q     <= '0;
            wr_accepted_q <= '0;
            wr_drained_q  <= '0;
            wr_count_q    <= '0;
            wr_wptr_q     <= '0;
            wr_rptr_q     <= '0;
            wr_wait_q     <= '0;
            wr_full_q     <= 1'b0;
        end else begin
            wr_state_q    <= wr_state_d;
            wr_base_q     <= wr_base_d;
            wr_size_q     <= wr_size_d;
            wr_accepted_q <= wr_accepted_d;
            wr_drained_q  <= wr_drained_d;
            wr_count_q    <= wr_count_d;
            wr_wptr_q     <= wr_wptr_d;
            wr_rptr_q     <= wr_rptr_d;
            wr_wait_q     <= wr_wait_d;
            wr_full_q     <= wr_full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_push) wr_fifo[wr_wptr_q] <= wr_data;
    end

    assign full    = wr_full_q;
    assign wr_done = (wr_state_q == WR_DONE);

    // ------------------------------------------------------------------
    // Memory: drain wins over the backdoor; reads see pre-edge contents.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_drain)   mem[wr_line] <= wr_fifo[wr_rptr_q];
        else if (bd_we) mem[bd_addr] <= bd_wdata;
        if (rd_issue)   rd_mem_q     <= mem[rd_line];
    end

    assign bd_rdata = mem[bd_addr];

endmodule

// File: tb/tb_dma_mem_responder.sv
module tb_dma_mem_responder;

    localparam int DW  = 64;
    localparam int AW  = 64;
    localparam int SW  = 17;
    localparam int ML  = 64;
    localparam int FD  = 4;
    localparam int WDI = 4;
    localparam int LW  = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_go, rd_en, empty, rd_done;
    logic [AW-1:0] rd_addr;
    logic [SW-1:0] rd_size;
    logic [DW-1:0] rd_data;
    logic          wr_go, wr_en, full, wr_done;
    logic [AW-1:0] wr_addr;
    logic [SW-1:0] wr_size;
    logic [DW-1:0] wr_data;
    logic          bd_we;
    logic [LW-1:0] bd_addr;
    logic [DW-1:0] bd_wdata, bd_rdata;

    dma_mem_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW),
        .MEM_LINES(ML), .FIFO_DEPTH(FD), .WR_DRAIN_INTERVAL(WDI)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_go(rd_go), .rd_addr(rd_addr), .rd_size(rd_size), .rd_en(rd_en),
        .rd_data(rd_data), .empty(empty), .rd_done(rd_done),
        .wr_go(wr_go), .wr_addr(wr_addr), .wr_size(wr_size), .wr_en(wr_en),
        .wr_data(wr_data), .full(full), .wr_done(wr_done),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] model_mem [ML];   // what memory should hold
    logic [DW-1:0] got [$];
    bit            timed_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input int a, input logic [DW-1:0] d);
        bd_addr  = LW'(a);
        bd_wdata = d;
        bd_we    = 1'b1;
        tick();
        bd_we    = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic bd_read(input int a, output logic [DW-1:0] d);
        bd_addr = LW'(a);
        tick();
        d = bd_rdata;
    endtask

    task automatic start_read(input logic [AW-1:0] a, input int s);
        rd_addr = a;
        rd_size = SW'(s);
        rd_go   = 1'b1;
        tick();
        rd_go   = 1'b0;
    endtask

    task automatic start_write(input logic [AW-1:0] a, input int s);
        wr_addr = a;
        wr_size = SW'(s);
        wr_go   = 1'b1;
        tick();
        wr_go   = 1'b0;
    endtask

    // Collects n popped lines into got[]; pads with X on timeout.
    task automatic pop_lines(input int n, input bit rnd);
        int guard = 0;
        got.delete();
        timed_out = 1'b0;
        while (got.size() < n) begin
            if (guard > 500) begin
                timed_out = 1'b1;
                break;
            end
            rd_en = 1'b0;
            if (!empty && (!rnd || $urandom_range(0, 1) == 1)) begin
                got.push_back(rd_data);
                rd_en = 1'b1;
            end
            tick();
            guard++;
        end
        rd_en = 1'b0;
        while (got.size() < n) got.push_back('x);
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_go = 0; rd_en = 0; wr_go = 0; wr_en = 0; bd_we = 0;
        rd_addr = '0; rd_size = '0; wr_addr = '0; wr_size = '0;
        wr_data = '0; bd_addr = '0; bd_wdata = '0;
        tick(); tick();
        n_checks++; if (empty !== 1'b1)  $display("FAIL rst_empty: got %b want 1", empty);   else n_pass++;
        n_checks++; if (full !== 1'b0)   $display("FAIL rst_full: got %b want 0", full);     else n_pass++;
        n_checks++; if (rd_done !== 1'b0) $display("FAIL rst_rd_done: got %b want 0", rd_done); else n_pass++;
        n_checks++; if (wr_done !== 1'b0) $display("FAIL rst_wr_done: got %b want 0", wr_done); else n_pass++;
        n_checks++; if (rd_data !== '0)  $display("FAIL rst_rd_data: got %h want 0", rd_data); else n_pass++;
        rst = 1'b0;
        tick();
        for (int i = 0; i < ML; i++) bd_write(i, {$urandom, $urandom});
    endtask

    task automatic test_read_basic();
        for (int k = 0; k < 8; k++) bd_write(k, DW'(k * 'h11));
        start_read('0, 8);
        n_checks++; if (empty !== 1'b1) $display("FAIL lat_edgeN: empty got %b want 1", empty); else n_pass++;
        tick();
        n_checks++; if (empty !== 1'b1) $display("FAIL lat_edgeN1: empty got %b want 1", empty); else n_pass++;
        tick();
        n_checks++; if (empty !== 1'b0) $display("FAIL lat_edgeN2: empty got %b want 0", empty); else n_pass++;
        pop_lines(8, 1'b0);
        n_checks++; if (timed_out) $display("FAIL basic_timeout: popped %0d want 8", 8); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (got[k] !== DW'(k * 'h11)) $display("FAIL basic_data[%0d]: got %h want %h", k, got[k], DW'(k * 'h11));
            else n_pass++;
        end
        n_checks++; if (rd_done !== 1'b1) $display("FAIL basic_rd_done: got %b want 1", rd_done); else n_pass++;
        n_checks++; if (empty !== 1'b1)   $display("FAIL basic_empty_end: got %b want 1", empty);  else n_pass++;
    endtask

    task automatic test_read_backpressure();
        logic [DW-1:0] old [8];
        start_read('0, 8);
        repeat (20) tick();
        n_checks++; if (empty !== 1'b0)   $display("FAIL bp_empty: got %b want 0", empty);     else n_pass++;
        n_checks++; if (rd_done !== 1'b0) $display("FAIL bp_rd_done: got %b want 0", rd_done); else n_pass++;
        // Lines already fetched keep old data; unfetched lines see the rewrite.
        for (int k = 0; k < 8; k++) begin
            old[k] = model_mem[k];
            bd_write(k, ~old[k]);
        end
        pop_lines(8, 1'b0);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (got[k] !== ((k < FD) ? old[k] : model_mem[k]))
                $display("FAIL bp_data[%0d]: got %h want %h", k, got[k], (k < FD) ? old[k] : model_mem[k]);
            else n_pass++;
        end
        n_checks++; if (rd_done !== 1'b1) $display("FAIL bp_rd_done_end: got %b want 1", rd_done); else n_pass++;
    endtask

    task automatic test_read_wrap();
        logic [AW-1:0] a;
        for (int k = 0; k < 4; k++) bd_write((ML - 2 + k) % ML, {$urandom, $urandom});
        a = AW'((ML - 2) * 64 + 'h2d) | (AW'(1) << 40);
        start_read(a, 4);
        pop_lines(4, 1'b1);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (got[k] !== model_mem[(ML - 2 + k) % ML])
                $display("FAIL wrap_data[%0d]: got %h want %h", k, got[k], model_mem[(ML - 2 + k) % ML]);
            else n_pass++;
        end
        n_checks++; if (rd_done !== 1'b1) $display("FAIL wrap_rd_done: got %b want 1", rd_done); else n_pass++;
    endtask

    task automatic test_read_size0();
        start_read('0, 2);
        start_read(AW'(5 * 64), 0);
        n_checks++; if (rd_done !== 1'b1) $display("FAIL sz0_rd_done: got %b want 1", rd_done); else n_pass++;
        n_checks++; if (empty !== 1'b1)   $display("FAIL sz0_empty: got %b want 1", empty);     else n_pass++;
        repeat (4) tick();
        n_checks++; if (empty !== 1'b1)   $display("FAIL sz0_empty_later: got %b want 1", empty); else n_pass++;
        n_checks++; if (rd_done !== 1'b1) $display("FAIL sz0_rd_done_later: got %b want 1", rd_done); else n_pass++;
    endtask

    task automatic test_read_restart();
        bd_write(16, {$urandom, $urandom});
        bd_write(17, {$urandom, $urandom});
        start_read('0, 8);
        pop_lines(1, 1'b0);
        n_checks++; if (got[0] !== model_mem[0]) $display("FAIL rs_first: got %h want %h", got[0], model_mem[0]); else n_pass++;
        repeat (6) tick();
        start_read(AW'(16 * 64), 2);
        n_checks++; if (empty !== 1'b1)   $display("FAIL rs_flush: empty got %b want 1", empty); else n_pass++;
        n_checks++; if (rd_done !== 1'b0) $display("FAIL rs_rd_done0: got %b want 0", rd_done); else n_pass++;
        pop_lines(2, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (got[k] !== model_mem[16 + k]) $display("FAIL rs_data[%0d]: got %h want %h", k, got[k], model_mem[16 + k]);
            else n_pass++;
        end
        n_checks++; if (rd_done !== 1'b1) $display("FAIL rs_rd_done: got %b want 1", rd_done); else n_pass++;
    endtask

    task automatic test_write_full();
        logic [DW-1:0] exp [$];
        logic [DW-1:0] old7, d;
        int acc = 0, extra = 0, guard = 0;
        old7 = model_mem[7];
        start_write(AW'('h40), 6);
        while ((acc < 6 || extra < 3) && guard < 300) begin
            wr_en   = 1'b1;
            wr_data = {$urandom, $urandom};
            if (acc < 6 && !full) begin
                exp.push_back(wr_data);
                acc++;
            end else if (acc >= 6) extra++;
            tick();
            guard++;
            if (guard == 3) begin
                n_checks++; if (full !== 1'b0) $display("FAIL wf_full_3: got %b want 0", full); else n_pass++;
            end
            if (guard == 4) begin
                n_checks++; if (full !== 1'b1) $display("FAIL wf_full_4: got %b want 1", full); else n_pass++;
            end
        end
        wr_en = 1'b0;
        guard = 0;
        while (!wr_done && guard < 300) begin tick(); guard++; end
        n_checks++; if (wr_done !== 1'b1) $display("FAIL wf_wr_done: got %b want 1", wr_done); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            bd_read(1 + k, d);
            n_checks++;
            if (d !== exp[k]) $display("FAIL wf_mem[%0d]: got %h want %h", 1 + k, d, exp[k]);
            else n_pass++;
            model_mem[1 + k] = exp[k];
        end
        bd_read(7, d);
        n_checks++; if (d !== old7) $display("FAIL wf_mem7: got %h want %h", d, old7); else n_pass++;
    endtask

    task automatic test_write_reset_mid();
        logic [DW-1:0] exp [$];
        logic [DW-1:0] d;
        int acc = 0, guard = 0;
        bit seen = 0;
        for (int k = 32; k < 37; k++) bd_write(k, {$urandom, $urandom});
        start_read('0, 2);
        start_write(AW'(32 * 64), 5);
        bd_addr = LW'(34);
        while (!seen && guard < 300) begin
            wr_en = 1'b0;
            if (acc < 5 && !full) begin
                wr_en   = 1'b1;
                wr_data = {$urandom, $urandom};
                exp.push_back(wr_data);
                acc++;
            end
            tick();
            guard++;
            if (acc >= 3 && bd_rdata === exp[2]) seen = 1;
        end
        wr_en = 1'b0;
        n_checks++; if (!seen) $display("FAIL rm_third_drain: waited %0d cycles", guard); else n_pass++;
        n_checks++; if (empty !== 1'b0) $display("FAIL rm_pre_empty: got %b want 0", empty); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (empty !== 1'b1)   $display("FAIL rm_empty: got %b want 1", empty);     else n_pass++;
        n_checks++; if (full !== 1'b0)    $display("FAIL rm_full: got %b want 0", full);       else n_pass++;
        n_checks++; if (rd_done !== 1'b0) $display("FAIL rm_rd_done: got %b want 0", rd_done); else n_pass++;
        n_checks++; if (wr_done !== 1'b0) $display("FAIL rm_wr_done: got %b want 0", wr_done); else n_pass++;
        repeat (20) tick();
        for (int k = 0; k < 3; k++) model_mem[32 + k] = exp[k];
        for (int k = 32; k < 37; k++) begin
            bd_read(k, d);
            n_checks++;
            if (d !== model_mem[k]) $display("FAIL rm_mem[%0d]: got %h want %h", k, d, model_mem[k]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            logic [DW-1:0] rexp [$];
            logic [DW-1:0] wexp [$];
            logic [DW-1:0] d;
            int rb, rs, wb, ws, acc, guard;
            bit wdone;
            rb = $urandom_range(0, 27); rs = $urandom_range(1, 12);
            wb = $urandom_range(40, 50); ws = $urandom_range(1, 10);
            for (int k = 0; k < rs; k++) rexp.push_back(model_mem[(rb + k) % ML]);
            rd_addr = AW'(rb * 64 + $urandom_range(0, 63)); rd_size = SW'(rs);
            wr_addr = AW'(wb * 64 + $urandom_range(0, 63)); wr_size = SW'(ws);
            rd_go = 1'b1; wr_go = 1'b1;
            tick();
            rd_go = 1'b0; wr_go = 1'b0;
            got.delete();
            acc = 0; guard = 0; wdone = 0;
            while ((got.size() < rs || !wdone) && guard < 2000) begin
                rd_en = 1'b0;
                if (!empty && got.size() < rs && $urandom_range(0, 3) != 0) begin
                    got.push_back(rd_data);
                    rd_en = 1'b1;
                end
                wr_en = 1'b0;
                if (acc < ws && !full && $urandom_range(0, 1) == 1) begin
                    wr_en   = 1'b1;
                    wr_data = {$urandom, $urandom};
                    wexp.push_back(wr_data);
                    acc++;
                end
                tick();
                guard++;
                if (wr_done) wdone = 1;
            end
            rd_en = 1'b0; wr_en = 1'b0;
            n_checks++; if (guard >= 2000) $display("FAIL rnd%0d_timeout: popped %0d of %0d", it, got.size(), rs); else n_pass++;
            while (got.size() < rs) got.push_back('x);
            for (int k = 0; k < rs; k++) begin
                n_checks++;
                if (got[k] !== rexp[k]) $display("FAIL rnd%0d_rd[%0d]: got %h want %h", it, k, got[k], rexp[k]);
                else n_pass++;
            end
            n_checks++; if (rd_done !== 1'b1) $display("FAIL rnd%0d_rd_done: got %b want 1", it, rd_done); else n_pass++;
            n_checks++; if (wr_done !== 1'b1) $display("FAIL rnd%0d_wr_done: got %b want 1", it, wr_done); else n_pass++;
            while (wexp.size() < ws) wexp.push_back('x);
            for (int k = 0; k < ws; k++) begin
                bd_read(wb + k, d);
                n_checks++;
                if (d !== wexp[k]) $display("FAIL rnd%0d_mem[%0d]: got %h want %h", it, wb + k, d, wexp[k]);
                else n_pass++;
                model_mem[wb + k] = wexp[k];
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_read_backpressure();
        test_read_wrap();
        test_read_size0();
        test_read_restart();
        test_write_full();
        test_write_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
